// File: rtl/seg_master_pkg.sv
// ---------------------------------------------------------------------------
// seg_master_pkg
//   Shared types and default constants for avalon_seg_write_master, the
//   on-chip Avalon-MM initiator that loads the seven-segment display slave.
//
//   state_t          FSM encoding: IDLE, WR_DATA, WR_CTRL, DONE, ERR
//   DFLT_DATA_OFS    default byte offset of the 32-bit digit register
//   DFLT_CTRL_OFS    default byte offset of the control register
//   DFLT_CTRL_WORD   default control value (display enable)
//   BYTEEN_ALL       byteenable driven with every write (full 32-bit word)
// ---------------------------------------------------------------------------
package seg_master_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_DATA = 3'd1,
        WR_CTRL = 3'd2,
        DONE    = 3'd3,
        ERR     = 3'd4
    } state_t;

    localparam int unsigned DFLT_DATA_OFS  = 0;
    localparam int unsigned DFLT_CTRL_OFS  = 4;
    localparam logic [31:0] DFLT_CTRL_WORD = 32'h0000_0001;
    localparam logic [3:0]  BYTEEN_ALL     = 4'hF;

endpackage : seg_master_pkg

// File: rtl/avalon_seg_write_master.sv
// ---------------------------------------------------------------------------
// avalon_seg_write_master
//   Avalon-MM initiator that pushes a 32-bit value (8 hex digits) into the
//   display slave: one write to the digit register, then one write to the
//   control register. Honours waitrequest and aborts a write that stays
//   stalled for TIMEOUT cycles.
//
//   Parameters
//     ADDR_W     avm_address width (byte address)
//     BASE_ADDR  display slave base address
//     DATA_OFS   byte offset of the digit register
//     CTRL_OFS   byte offset of the control register
//     CTRL_WORD  value written to the control register
//     TIMEOUT    max waitrequest-high cycles per write (>= 2)
//
//   Ports
//     clk              in   system clock
//     reset_n          in   asynchronous active-low reset
//     start            in   request a transfer (sampled only in IDLE)
//     value            in   digits to display, captured with start
//     busy             out  high from accepted start until done/error
//     done             out  1-cycle pulse, both writes accepted
//     error            out  1-cycle pulse, a write timed out
//     avm_address      out  Avalon byte address
//     avm_write        out  Avalon write strobe
//     avm_writedata    out  Avalon write data
//     avm_byteenable   out  4'hF while avm_write is high, else 0
//     avm_waitrequest  in   slave stall
// ---------------------------------------------------------------------------
module avalon_seg_write_master
    import seg_master_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       DATA_OFS  = DFLT_DATA_OFS,
    parameter int unsigned       CTRL_OFS  = DFLT_CTRL_OFS,
    parameter logic [31:0]       CTRL_WORD = DFLT_CTRL_WORD,
    parameter int unsigned       TIMEOUT   = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [31:0]       value,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    output logic [3:0]        avm_byteenable,
    input  logic              avm_waitrequest
);

    localparam int unsigned       CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    // Sums are taken at ADDR_W bits, so a base near the top of the address
    // space simply wraps.
    localparam logic [ADDR_W-1:0] DATA_ADDR = BASE_ADDR + ADDR_W'(DATA_OFS);
    localparam logic [ADDR_W-1:0] CTRL_ADDR = BASE_ADDR + ADDR_W'(CTRL_OFS);

    state_t              state_q,      state_d;
    logic [31:0]         value_q,      value_d;
    logic [CNT_W-1:0]    cnt_q,        cnt_d;
    logic                busy_q,       busy_d;
    logic                done_q,       done_d;
    logic                error_q,      error_d;
    logic                write_q,      write_d;
    logic [ADDR_W-1:0]   address_q,    address_d;
    logic [31:0]         writedata_q,  writedata_d;
    logic [3:0]          byteenable_q, byteenable_d;

    // Next-state logic. Every output is a registered function of the next
    // state, so the bus signals change only on clock edges and stay frozen
    // while the slave stalls.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned; an unassigned path would infer a latch.
        state_d = state_q;
        value_d = value_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    value_d = value;
                    cnt_d   = '0;
                    state_d = WR_DATA;
                end
            end
            WR_DATA: begin
                if (!avm_waitrequest) begin
                    cnt_d   = '0;
                    state_d = WR_CTRL;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WR_CTRL: begin
                if (!avm_waitrequest) begin
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        write_d      = (state_d == WR_DATA) || (state_d == WR_CTRL);
        busy_d       = write_d;
        done_d       = (state_d == DONE);
        error_d      = (state_d == ERR);
        byteenable_d = write_d ? BYTEEN_ALL : 4'h0;

        unique case (state_d)
            WR_DATA: begin
                address_d   = DATA_ADDR;
                writedata_d = value_d;
            end
            WR_CTRL: begin
                address_d   = CTRL_ADDR;
                writedata_d = CTRL_WORD;
            end
            default: begin
                address_d   = '0;
                writedata_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            value_q      <= '0;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            write_q      <= 1'b0;
            address_q    <= '0;
            writedata_q  <= '0;
            byteenable_q <= 4'h0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values, independent of statement order.
            state_q      <= state_d;
            value_q      <= value_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            write_q      <= write_d;
            address_q    <= address_d;
            writedata_q  <= writedata_d;
            byteenable_q <= byteenable_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
    assign avm_write      = write_q;
    assign avm_address    = address_q;
    assign avm_writedata  = writedata_q;
    assign avm_byteenable = byteenable_q;

endmodule : avalon_seg_write_master

// File: tb/tb_avalon_seg_write_master.sv
// ---------------------------------------------------------------------------
// tb_avalon_seg_write_master
//   Directed bench for avalon_seg_write_master. Instance dut_a uses a
//   mid-range base and TIMEOUT=16; instance dut_b sits at the top of the
//   address space so its control write wraps to address 0. Inputs change on
//   the falling edge, outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_avalon_seg_write_master;

    localparam logic [31:0] BASE_A = 32'h8000_0040;
    localparam logic [31:0] BASE_B = 32'hFFFF_FFFC;

    logic        clk;
    logic        reset_n;

    logic        start_a, busy_a, done_a, error_a, write_a, waitreq_a;
    logic [31:0] value_a, addr_a, wdata_a;
    logic [3:0]  be_a;

    logic        start_b, busy_b, done_b, error_b, write_b, waitreq_b;
    logic [31:0] value_b, addr_b, wdata_b;
    logic [3:0]  be_b;

    int n_checks = 0;
    int n_errors = 0;

    avalon_seg_write_master #(
        .ADDR_W    (32),
        .BASE_ADDR (BASE_A),
        .TIMEOUT   (16)
    ) dut_a (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start_a),
        .value           (value_a),
        .busy            (busy_a),
        .done            (done_a),
        .error           (error_a),
        .avm_address     (addr_a),
        .avm_write       (write_a),
        .avm_writedata   (wdata_a),
        .avm_byteenable  (be_a),
        .avm_waitrequest (waitreq_a)
    );

    avalon_seg_write_master #(
        .ADDR_W    (32),
        .BASE_ADDR (BASE_B)
    ) dut_b (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start_b),
        .value           (value_b),
        .busy            (busy_b),
        .done            (done_b),
        .error           (error_b),
        .avm_address     (addr_b),
        .avm_write       (write_b),
        .avm_writedata   (wdata_b),
        .avm_byteenable  (be_b),
        .avm_waitrequest (waitreq_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Bus + status of dut_a; address/data/byteenable only matter while writing.
    task automatic check_a(input string tag, input logic w, input logic [31:0] addr,
                           input logic [31:0] data, input logic b, input logic d,
                           input logic e);
        check({tag, "_write"}, 64'(write_a), 64'(w));
        if (w) begin
            check({tag, "_addr"}, 64'(addr_a), 64'(addr));
            check({tag, "_data"}, 64'(wdata_a), 64'(data));
            check({tag, "_be"},   64'(be_a),    64'(4'hF));
        end
        check({tag, "_busy"},  64'(busy_a),  64'(b));
        check({tag, "_done"},  64'(done_a),  64'(d));
        check({tag, "_error"}, 64'(error_a), 64'(e));
    endtask

    initial begin
        reset_n   = 1'b0;
        start_a   = 1'b0;  value_a = '0;  waitreq_a = 1'b0;
        start_b   = 1'b0;  value_b = '0;  waitreq_b = 1'b0;

        // Reset state: every output 0.
        repeat (2) @(negedge clk);
        check("rst_write", 64'(write_a), 64'(0));
        check("rst_addr",  64'(addr_a),  64'(0));
        check("rst_data",  64'(wdata_a), 64'(0));
        check("rst_be",    64'(be_a),    64'(0));
        check("rst_busy",  64'(busy_a),  64'(0));
        check("rst_done",  64'(done_a),  64'(0));
        check("rst_error", 64'(error_a), 64'(0));
        reset_n = 1'b1;

        // 1: back-to-back writes with no stall, done 3 cycles after start.
        @(negedge clk); start_a = 1'b1; value_a = 32'h1234_ABCD;
        @(negedge clk); start_a = 1'b0;
        check_a("t1_data", 1, BASE_A, 32'h1234_ABCD, 1, 0, 0);
        @(negedge clk); check_a("t1_ctrl", 1, BASE_A + 4, 32'h0000_0001, 1, 0, 0);
        @(negedge clk); check_a("t1_done", 0, 0, 0, 0, 1, 0);
        @(negedge clk); check_a("t1_idle", 0, 0, 0, 0, 0, 0);

        // 2: data write stalled 5 cycles -> held stable for 6 cycles.
        waitreq_a = 1'b1; start_a = 1'b1; value_a = 32'h0A0B_0C0D;
        @(negedge clk); start_a = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check_a($sformatf("t2_hold%0d", i), 1, BASE_A, 32'h0A0B_0C0D, 1, 0, 0);
            if (i == 5) waitreq_a = 1'b0;
            @(negedge clk);
        end
        check_a("t2_ctrl", 1, BASE_A + 4, 32'h0000_0001, 1, 0, 0);
        @(negedge clk); check_a("t2_done", 0, 0, 0, 0, 1, 0);
        @(negedge clk); check_a("t2_idle", 0, 0, 0, 0, 0, 0);

        // 3: ctrl write stuck -> write held 16 cycles, then error pulse.
        start_a = 1'b1; value_a = 32'h1111_2222;
        @(negedge clk); start_a = 1'b0;
        check_a("t3_data", 1, BASE_A, 32'h1111_2222, 1, 0, 0);
        @(negedge clk); waitreq_a = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check_a($sformatf("t3_stall%0d", i), 1, BASE_A + 4, 32'h0000_0001, 1, 0, 0);
            @(negedge clk);
        end
        check_a("t3_err", 0, 0, 0, 0, 0, 1);
        @(negedge clk); waitreq_a = 1'b0;
        check_a("t3_idle", 0, 0, 0, 0, 0, 0);

        // 4: start held high with new value during transfer and DONE -> ignored;
        //    the first start after returning to IDLE is accepted.
        start_a = 1'b1; value_a = 32'h1234_ABCD;
        @(negedge clk); value_a = 32'hFFFF_FFFF;
        check_a("t4_data", 1, BASE_A, 32'h1234_ABCD, 1, 0, 0);
        @(negedge clk); check_a("t4_ctrl", 1, BASE_A + 4, 32'h0000_0001, 1, 0, 0);
        @(negedge clk); check_a("t4_done", 0, 0, 0, 0, 1, 0);
        @(negedge clk); check_a("t4_idle", 0, 0, 0, 0, 0, 0);
        @(negedge clk); start_a = 1'b0;
        check_a("t4_restart", 1, BASE_A, 32'hFFFF_FFFF, 1, 0, 0);
        @(negedge clk); check_a("t4_rctrl", 1, BASE_A + 4, 32'h0000_0001, 1, 0, 0);
        @(negedge clk); check_a("t4_rdone", 0, 0, 0, 0, 1, 0);

        // 5: reset during a stalled data write -> bus drops at once, no pulses.
        @(negedge clk); waitreq_a = 1'b1; start_a = 1'b1; value_a = 32'h5A5A_5A5A;
        @(negedge clk); start_a = 1'b0;
        check_a("t5_stall0", 1, BASE_A, 32'h5A5A_5A5A, 1, 0, 0);
        @(negedge clk);
        check_a("t5_stall1", 1, BASE_A, 32'h5A5A_5A5A, 1, 0, 0);
        #2 reset_n = 1'b0;
        #1;
        check("t5_rst_write", 64'(write_a), 64'(0));
        check("t5_rst_be",    64'(be_a),    64'(0));
        check_a("t5_rst", 0, 0, 0, 0, 0, 0);
        @(negedge clk); check_a("t5_rst_hold", 0, 0, 0, 0, 0, 0);
        waitreq_a = 1'b0; reset_n = 1'b1;
        @(negedge clk); start_a = 1'b1; value_a = 32'h600D_F00D;
        @(negedge clk); start_a = 1'b0;
        check_a("t5_data", 1, BASE_A, 32'h600D_F00D, 1, 0, 0);
        @(negedge clk); check_a("t5_ctrl", 1, BASE_A + 4, 32'h0000_0001, 1, 0, 0);
        @(negedge clk); check_a("t5_done", 0, 0, 0, 0, 1, 0);

        // 6: base at top of address space -> ctrl write wraps to 0.
        @(negedge clk); start_b = 1'b1; value_b = 32'h0BAD_F00D;
        @(negedge clk); start_b = 1'b0;
        check("t6_data_write", 64'(write_b), 64'(1));
        check("t6_data_addr",  64'(addr_b),  64'(32'hFFFF_FFFC));
        check("t6_data_data",  64'(wdata_b), 64'(32'h0BAD_F00D));
        @(negedge clk);
        check("t6_ctrl_write", 64'(write_b), 64'(1));
        check("t6_ctrl_addr",  64'(addr_b),  64'(32'h0000_0000));
        check("t6_ctrl_data",  64'(wdata_b), 64'(32'h0000_0001));
        check("t6_ctrl_be",    64'(be_b),    64'(4'hF));
        @(negedge clk);
        check("t6_done",       64'(done_b),  64'(1));
        check("t6_done_write", 64'(write_b), 64'(0));
        check("t6_done_error", 64'(error_b), 64'(0));
        check("t6_done_busy",  64'(busy_b),  64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_avalon_seg_write_master
